seg7_scan_reader: RTL and testbench



---
 rtl/seg7_scan_reader.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers a 4-digit BCD frame from the active-low,
// multiplexed 7-segment bus so the stopwatch can read back its display.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   seg_in[0:6]    : segment lines a..g, active-low
//   dig_en[3:0]    : digit selects, active-low one-hot
//   err_clr        : sync clear of err / err_count
//   bcd_out[15:0]  : last complete frame, [15:12] = digit 3
//   frame_valid    : one-cycle pulse when bcd_out updates
//   err            : sticky bad-pattern flag
//   err_count[7:0] : saturating bad-pattern count
// Define SEG7_READER_ERRCNT_EN to build the err_count counter;
// otherwise err_count is tied to zero.
module seg7_scan_reader #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:6]  seg_in,
    input  logic [3:0]  dig_en,
    input  logic        err_clr,
    output logic [15:0] bcd_out,
    output logic        frame_valid,
    output logic        err,
    output logic [7:0]  err_count
);
    localparam logic [3:0] STAB = 4'(STABLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, run;
    logic [3:0]  den_q;
    logic [0:6]  seg_q;
    logic [10:0] word, prev_q;
    logic        same, sel_ok, seg_ok;
    logic        cap, good, bad, full;
    logic [1:0]  pos;
    logic [3:0]  val;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] shadow_q, shadow_d;

    assign word = {den_q, seg_q};
    // prev_q is the word the FSM saw last cycle; any
    // difference restarts the stability count.
    assign same = (word == prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            den_q  <= '1;
            seg_q  <= '1;
            prev_q <= '1;
        end else begin
            den_q  <= dig_en;
            seg_q  <= seg_in;
            prev_q <= word;
        end
    end

    always_comb begin
        sel_ok = 1'b1;
        pos    = 2'd0;
        unique case (1'b1)
            (den_q == 4'b1110): pos = 2'd0;
            (den_q == 4'b1101): pos = 2'd1;
            (den_q == 4'b1011): pos = 2'd2;
            (den_q == 4'b0111): pos = 2'd3;
            default:            sel_ok = 1'b0;
        endcase
    end

    always_comb begin
        seg_ok = 1'b1;
        val    = 4'd0;
        case (seg_q)
            7'b0000001: val = 4'd0;
            7'b1001111: val = 4'd1;
            7'b0010010: val = 4'd2;
            7'b0000110: val = 4'd3;
            7'b1001100: val = 4'd4;
            7'b0100100: val = 4'd5;
            7'b0100000: val = 4'd6;
            7'b0001101: val = 4'd7;
            7'b0000000: val = 4'd8;
            7'b0000100: val = 4'd9;
            default:    seg_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // run is the stable-cycle count including this cycle; a
    // fresh word starts at 1 so STABLE_CYC=1 captures at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        run     = (state_q == SETTLE && same) ? cnt_q + 4'd1 : 4'd1;
        if (!sel_ok) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!(state_q == HOLD && same)) begin
            cnt_d = run;
            if (run == STAB) begin
                state_d = HOLD;
                cap     = 1'b1;
            end else begin
                state_d = SETTLE;
            end
        end
    end

    assign good = cap & seg_ok;
    assign bad  = cap & ~seg_ok;
    assign full = (mask_q == 4'hF);

    // A full mask publishes on this edge; a capture on the
    // same edge already belongs to the next frame.
    always_comb begin
        mask_d   = full ? 4'h0 : mask_q;
        shadow_d = shadow_q;
        if (good) begin
            mask_d[pos]                 = 1'b1;
            shadow_d[{pos, 2'b00} +: 4] = val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            shadow_q    <= '0;
            bcd_out     <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            shadow_q    <= shadow_d;
            frame_valid <= full;
            if (full) begin
                bcd_out <= shadow_q;
            end
            if (bad) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0] ecnt_q;

    // A bad capture beats a simultaneous clear: count restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt_q <= '0;
        end else if (bad) begin
            if (err_clr) begin
                ecnt_q <= 8'd1;
            end else if (ecnt_q != 8'hFF) begin
                ecnt_q <= ecnt_q + 8'd1;
            end
        end else if (err_clr) begin
            ecnt_q <= '0;
        end
    end

    assign err_count = ecnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed and random readback scenarios
// for seg7_scan_reader against a run-length reference model.
module tb_seg7_scan_reader;
    localparam int S = 4;
`ifdef SEG7_READER_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:6]  seg_in;
    logic [3:0]  dig_en;
    logic        err_clr;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    seg7_scan_reader #(.STABLE_CYC(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .err_clr     (err_clr),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .err         (err),
        .err_count   (err_count)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_fv = 0;
    int fv_cyc = 0;
    int start_cyc = 0;

    logic [6:0] pat [10];

    logic [10:0] m_inq;
    int          m_run;
    logic [3:0]  m_mask;
    logic [15:0] m_shadow;
    logic [15:0] e_bcd;
    logic        e_fv;
    logic        e_err;
    int          e_cnt;

    task automatic m_reset();
        m_inq    = '1;
        m_run    = 0;
        m_mask   = '0;
        m_shadow = '0;
        e_bcd    = '0;
        e_fv     = 1'b0;
        e_err    = 1'b0;
        e_cnt    = 0;
    endtask

    // A word is captured on the edge where it has been held
    // in the input register for exactly S consecutive edges.
    task automatic m_step(input logic [3:0] d, input logic [6:0] s,
                          input logic c);
        int nz, p, v;
        logic cap;
        nz = 0;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            if (!m_inq[7+i]) begin
                nz++;
                p = i;
            end
        end
        v = -1;
        for (int k = 0; k < 10; k++) begin
            if (m_inq[6:0] == pat[k]) v = k;
        end
        cap = (nz == 1) && (m_run == S);
        e_fv = (m_mask == 4'hF);
        if (e_fv) begin
            e_bcd  = m_shadow;
            m_mask = '0;
        end
        if (cap && v >= 0) begin
            m_shadow[p*4 +: 4] = 4'(v);
            m_mask[p] = 1'b1;
        end
        if (cap && v < 0) begin
            e_err = 1'b1;
            if (c) e_cnt = 0;
            if (CNT_EN && e_cnt < 255) e_cnt++;
        end else if (c) begin
            e_err = 1'b0;
            e_cnt = 0;
        end
        if ({d, s} == m_inq) m_run++;
        else m_run = 1;
        m_inq = {d, s};
    endtask

    task automatic tick(input logic [3:0] d, input logic [6:0] s,
                        input logic c);
        @(negedge clk);
        dig_en  = d;
        seg_in  = s;
        err_clr = c;
        @(posedge clk);
        m_step(d, s, c);
        cyc++;
        #1;
        if (frame_valid === 1'b1) begin
            n_fv++;
            fv_cyc = cyc;
        end
    endtask

    task automatic scan_raw(input logic [3:0] d, input logic [6:0] p,
                            input int dwell, input int gap);
        start_cyc = cyc + 1;
        for (int i = 0; i < dwell; i++) tick(d, p, 1'b0);
        for (int i = 0; i < gap; i++) tick(4'hF, 7'h7F, 1'b0);
    endtask

    task automatic scan(input int p, input int v, input int dwell,
                        input int gap);
        logic [3:0] d;
        d = ~(4'b0001 << p);
        scan_raw(d, pat[v], dwell, gap);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        dig_en  = 4'hF;
        seg_in  = 7'h7F;
        err_clr = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bcd_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_bcd: got %h want 0000", bcd_out);
        end
        n_vec++;
        if (frame_valid !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: fv=%b err=%b want 0 0",
                     frame_valid, err);
        end
        n_vec++;
        if (err_count !== 8'h00) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d want 0", err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame();
        n_fv = 0;
        scan(3, 1, 8, 2);
        scan(2, 2, 8, 2);
        scan(1, 3, 8, 2);
        scan(0, 4, 8, 2);
        n_vec++;
        if (bcd_out !== 16'h1234 || e_bcd !== 16'h1234) begin
            n_err++;
            $display("FAIL frame_bcd: got %h model %h want 1234",
                     bcd_out, e_bcd);
        end
        n_vec++;
        if (n_fv !== 1) begin
            n_err++;
            $display("FAIL frame_pulses: got %0d want 1", n_fv);
        end
        n_vec++;
        if (fv_cyc - start_cyc !== S + 1) begin
            n_err++;
            $display("FAIL frame_latency: got %0d want %0d",
                     fv_cyc - start_cyc, S + 1);
        end
    endtask

    task automatic test_glitch();
        n_fv = 0;
        scan(0, 5, S - 1, 2);
        scan(3, 7, 8, 2);
        scan(2, 8, 8, 2);
        scan(1, 9, 8, 2);
        n_vec++;
        if (n_fv !== 0) begin
            n_err++;
            $display("FAIL glitch_short: got %0d pulses want 0", n_fv);
        end
        scan(0, 5, S, 3);
        n_vec++;
        if (n_fv !== 1 || bcd_out !== 16'h7895) begin
            n_err++;
            $display("FAIL glitch_exact: pulses %0d bcd %h want 1 7895",
                     n_fv, bcd_out);
        end
    endtask

    task automatic test_bad();
        n_fv = 0;
        scan(3, 1, 8, 2);
        scan(1, 3, 8, 2);
        scan(0, 4, 8, 2);
        scan_raw(4'b1011, 7'b1111110, 8, 2);
        n_vec++;
        if (err !== 1'b1 || n_fv !== 0) begin
            n_err++;
            $display("FAIL bad_flag: err=%b pulses=%0d want 1 0",
                     err, n_fv);
        end
        n_vec++;
        if (err_count !== 8'(CNT_EN ? 1 : 0)) begin
            n_err++;
            $display("FAIL bad_count: got %0d want %0d",
                     err_count, CNT_EN ? 1 : 0);
        end
        tick(4'hF, 7'h7F, 1'b1);
        tick(4'hF, 7'h7F, 1'b0);
        n_vec++;
        if (err !== 1'b0 || err_count !== 8'h00) begin
            n_err++;
            $display("FAIL bad_clr: err=%b cnt=%0d want 0 0",
                     err, err_count);
        end
        scan(2, 6, 8, 2);
        n_vec++;
        if (n_fv !== 1 || bcd_out !== 16'h1634) begin
            n_err++;
            $display("FAIL bad_nibble: pulses %0d bcd %h want 1 1634",
                     n_fv, bcd_out);
        end
    endtask

    task automatic test_invalid_sel();
        n_fv = 0;
        scan_raw(4'b1100, pat[2], 10, 2);
        scan(3, 5, 8, 2);
        scan(2, 5, 8, 2);
        scan(1, 5, 8, 2);
        n_vec++;
        if (n_fv !== 0) begin
            n_err++;
            $display("FAIL invalid_sel: got %0d pulses want 0", n_fv);
        end
        scan(0, 0, 8, 2);
        n_vec++;
        if (n_fv !== 1 || bcd_out !== 16'h5550) begin
            n_err++;
            $display("FAIL invalid_frame: pulses %0d bcd %h want 1 5550",
                     n_fv, bcd_out);
        end
    endtask

    task automatic test_reset_mid();
        scan(3, 1, 8, 2);
        scan(2, 2, 8, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        m_reset();
        n_vec++;
        if (bcd_out !== 16'h0000 || frame_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: bcd %h fv %b want 0000 0",
                     bcd_out, frame_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_fv = 0;
        scan(3, 9, 8, 2);
        scan(2, 8, 8, 2);
        scan(1, 7, 8, 2);
        scan(0, 6, 8, 2);
        n_vec++;
        if (n_fv !== 1 || bcd_out !== 16'h9876) begin
            n_err++;
            $display("FAIL reset_mid: pulses %0d bcd %h want 1 9876",
                     n_fv, bcd_out);
        end
    endtask

    task automatic test_err_precedence();
        scan_raw(4'b1110, 7'b1010101, 8, 2);
        for (int k = 0; k < 8; k++) begin
            tick(4'b1101, 7'b0110110, k == S);
        end
        tick(4'hF, 7'h7F, 1'b0);
        n_vec++;
        if (err !== 1'b1 || err_count !== 8'(CNT_EN ? 1 : 0)) begin
            n_err++;
            $display("FAIL err_prec: err=%b cnt=%0d want 1 %0d",
                     err, err_count, CNT_EN ? 1 : 0);
        end
        for (int n = 0; n < 300; n++) begin
            scan_raw(4'b0111, (n % 2) ? 7'b1010101 : 7'b0110110, S, 0);
        end
        tick(4'hF, 7'h7F, 1'b0);
        n_vec++;
        if (err !== 1'b1 || err_count !== 8'(CNT_EN ? 255 : 0)) begin
            n_err++;
            $display("FAIL err_sat: err=%b cnt=%0d want 1 %0d",
                     err, err_count, CNT_EN ? 255 : 0);
        end
        tick(4'hF, 7'h7F, 1'b1);
        tick(4'hF, 7'h7F, 1'b0);
        n_vec++;
        if (err !== 1'b0 || err_count !== 8'h00) begin
            n_err++;
            $display("FAIL err_sat_clr: err=%b cnt=%0d want 0 0",
                     err, err_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic [6:0] p;
        int kind, dwell;
        for (int seg = 0; seg < 300; seg++) begin
            kind = $urandom % 10;
            if (kind == 0) begin
                d = 4'hF;
            end else if (kind == 1) begin
                d = 4'($urandom);
                if ($countones(~d) == 1) d = 4'b0000;
            end else begin
                d = ~(4'b0001 << ($urandom % 4));
            end
            if ($urandom % 8 == 0) p = 7'($urandom);
            else p = pat[$urandom % 10];
            dwell = $urandom_range(1, 7);
            for (int i = 0; i < dwell; i++) begin
                tick(d, p, ($urandom % 20) == 0);
                n_vec++;
                if ({bcd_out, frame_valid, err, err_count} !==
                    {e_bcd, e_fv, e_err, 8'(e_cnt)}) begin
                    n_err++;
                    if (n_err < 30)
                        $display({"FAIL random: cyc %0d got %h/%b/%b/%0d",
                                  " want %h/%b/%b/%0d"}, cyc,
                                 bcd_out, frame_valid, err, err_count,
                                 e_bcd, e_fv, e_err, e_cnt);
                end
            end
        end
    endtask

    initial begin
        pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                7'b0000000, 7'b0000100};
        test_reset();
        test_frame();
        test_glitch();
        test_bad();
        test_invalid_sel();
        test_reset_mid();
        test_err_precedence();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
